// File: rtl/fix_acc_dump.sv
// fix_acc_dump: fixed-point accumulate-and-dump stage.
//
// Sums frame_len consecutive signed samples in a full-precision accumulator,
// arithmetic-shifts the sum right by SHIFT_CONST, saturates it to OUT_WIDTH
// and presents it on a valid/ready output.
//
// Optional feature: define FIX_ACC_DUMP_ROUND_EN to round half up before the
// shift (adds 2^(SHIFT_CONST-1)); otherwise the shift truncates (floor).
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in         signed input sample (IN_WIDTH)
//   in_valid   sample valid
//   in_ready   stage can accept a sample (registered)
//   frame_len  samples per frame, sampled with the first sample of a frame
//   flush      synchronous abort of the current frame / pending result
//   out        signed shifted, saturated frame sum (OUT_WIDTH)
//   out_valid  out holds a completed frame result
//   out_ready  downstream accepts out
module fix_acc_dump #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int MAX_LEN     = 64,
  parameter int SHIFT_CONST = 3,
  localparam int LEN_W      = $clog2(MAX_LEN + 1),
  localparam int ACC_WIDTH  = IN_WIDTH + $clog2(MAX_LEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [IN_WIDTH-1:0]  in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic        [LEN_W-1:0]     frame_len,
  input  logic                        flush,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int WW = ACC_WIDTH + 1;  // rounding headroom

  // Half an output LSB; evaluates to 0 when SHIFT_CONST is 0.
`ifdef FIX_ACC_DUMP_ROUND_EN
  localparam logic signed [WW-1:0] RoundAdd = (WW'(1) << SHIFT_CONST) >> 1;
`else
  localparam logic signed [WW-1:0] RoundAdd = '0;
`endif

  localparam logic signed [WW-1:0] SatMax =
    {{(WW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [WW-1:0] SatMin =
    {{(WW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic        [LEN_W-1:0]       cnt_q, cnt_d;
  logic        [LEN_W-1:0]       len_q, len_d;
  logic signed [OUT_WIDTH-1:0]   out_q, out_d;
  logic                          out_valid_q, out_valid_d;
  logic                          in_ready_q, in_ready_d;

  logic                          accept;
  logic                          first;
  logic        [LEN_W-1:0]       len_eff;
  logic        [LEN_W-1:0]       len_cur;
  logic        [LEN_W-1:0]       cnt_inc;
  logic signed [ACC_WIDTH-1:0]   in_ext;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic signed [WW-1:0]          rounded;
  logic signed [WW-1:0]          shifted;
  logic signed [OUT_WIDTH-1:0]   sat_val;

  // Datapath for the sample being accepted this cycle.
  always_comb begin
    accept  = in_valid && in_ready_q;
    first   = (cnt_q == '0);
    len_eff = frame_len;
    if (frame_len == '0) begin
      len_eff = LEN_W'(1);
    end else if (frame_len > LEN_W'(MAX_LEN)) begin
      len_eff = LEN_W'(MAX_LEN);
    end
    // frame_len only matters on the first sample; later samples use len_q.
    len_cur = first ? len_eff : len_q;
    cnt_inc = cnt_q + 1'b1;
    in_ext  = {{(ACC_WIDTH - IN_WIDTH){in[IN_WIDTH-1]}}, in};
    acc_sum = first ? in_ext : (acc_q + in_ext);
    rounded = {acc_sum[ACC_WIDTH-1], acc_sum} + RoundAdd;
    shifted = rounded >>> SHIFT_CONST;
    if (shifted > SatMax) begin
      sat_val = SatMax[OUT_WIDTH-1:0];
    end else if (shifted < SatMin) begin
      sat_val = SatMin[OUT_WIDTH-1:0];
    end else begin
      sat_val = shifted[OUT_WIDTH-1:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      // Flush beats a simultaneous accept: the sample is dropped.
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      state_d     = StAcc;
    end else begin
      unique case (state_q)
        StIdle: state_d = StAcc;
        StAcc: begin
          if (accept) begin
            if (first) begin
              len_d = len_eff;
            end
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            if (cnt_inc == len_cur) begin
              out_d       = sat_val;
              cnt_d       = '0;
              out_valid_d = 1'b1;
              state_d     = StHold;
            end
          end
        end
        StHold: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StAcc;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    in_ready_d = (state_d == StAcc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fix_acc_dump.sv
// Bench for fix_acc_dump: two instances (SHIFT_CONST 2 and 0) share stimulus;
// table-driven frames plus hand sequences for back-pressure, flush and reset.
module tb_fix_acc_dump;

`ifdef FIX_ACC_DUMP_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [15:0] din;
  logic               in_valid;
  logic [6:0]         frame_len;
  logic               flush;
  logic               out_ready;
  logic               in_ready2, in_ready0;
  logic signed [15:0] out2, out0;
  logic               valid2, valid0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fix_acc_dump #(.SHIFT_CONST(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready2),
    .frame_len(frame_len), .flush(flush), .out(out2), .out_valid(valid2),
    .out_ready(out_ready)
  );

  fix_acc_dump #(.SHIFT_CONST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready0),
    .frame_len(frame_len), .flush(flush), .out(out0), .out_valid(valid0),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [31:0]       len;
    logic [31:0]       n;
    logic [7:0][15:0]  s;
    logic [31:0]       e2;
    logic [31:0]       e0;
  } vec_t;

  function automatic vec_t mk(input int len, input int n,
                              input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7,
                              input int e2, input int e0);
    vec_t v;
    v.len = len;
    v.n   = n;
    v.s[0] = 16'(a0); v.s[1] = 16'(a1); v.s[2] = 16'(a2); v.s[3] = 16'(a3);
    v.s[4] = 16'(a4); v.s[5] = 16'(a5); v.s[6] = 16'(a6); v.s[7] = 16'(a7);
    v.e2 = e2;
    v.e0 = e0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives the samples of one frame; returns #1 after the last accept edge.
  // frame_len is scrambled after the first sample to show it is only sampled once.
  task automatic feed(input vec_t v);
    int w;
    for (int i = 0; i < int'(v.n); i++) begin
      w = 0;
      while (!in_ready2 && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!in_ready2) chk("in_ready_timeout", 0, 1);
      in_valid  = 1'b1;
      din       = v.s[i];
      frame_len = (i == 0) ? v.len[6:0] : 7'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_done(input string tag, input int e2, input int e0);
    chk({tag, "_valid2"}, int'(valid2), 1);
    chk({tag, "_valid0"}, int'(valid0), 1);
    chk({tag, "_out2"}, int'(out2), e2);
    chk({tag, "_out0"}, int'(out0), e0);
    chk({tag, "_ready_hold"}, int'(in_ready2), 0);
  endtask

  task automatic check_release(input string tag);
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, int'(valid2 | valid0), 0);
    chk({tag, "_ready_back"}, int'(in_ready2 & in_ready0), 1);
  endtask

  vec_t tbl [9];
  vec_t v;

  initial begin
    tbl[0] = mk(4, 4, 100, 200, -50, 10, 0, 0, 0, 0, 65, 260);
    tbl[1] = mk(8, 8, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                32767, 32767);
    tbl[2] = mk(4, 4, -32768, -32768, -32768, -32768, 0, 0, 0, 0, -32768, -32768);
    tbl[3] = mk(2, 2, 3, 3, 0, 0, 0, 0, 0, 0, Rnd ? 2 : 1, 6);
    tbl[4] = mk(2, 2, -3, -3, 0, 0, 0, 0, 0, 0, Rnd ? -1 : -2, -6);
    tbl[5] = mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    tbl[6] = mk(0, 1, -9, 0, 0, 0, 0, 0, 0, 0, Rnd ? -2 : -3, -9);
    tbl[7] = mk(3, 3, 1000, -3000, 500, 0, 0, 0, 0, 0, -375, -1500);
    tbl[8] = mk(1, 1, -32768, 0, 0, 0, 0, 0, 0, 0, -8192, -32768);

    rst_n = 1'b0; din = '0; in_valid = 1'b0; frame_len = '0; flush = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out2", int'(out2), 0);
    chk("rst_out0", int'(out0), 0);
    chk("rst_valid", int'(valid2 | valid0), 0);
    chk("rst_ready", int'(in_ready2 | in_ready0), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_ready", int'(in_ready2 & in_ready0), 1);

    for (int k = 0; k < 9; k++) begin
      feed(tbl[k]);
      check_done($sformatf("vec%0d", k), int'(tbl[k].e2), int'(tbl[k].e0));
      check_release($sformatf("vec%0d", k));
    end

    // Back-pressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    v = mk(2, 2, 10, 20, 0, 0, 0, 0, 0, 0, Rnd ? 8 : 7, 30);
    feed(v);
    check_done("bp", int'(v.e2), int'(v.e0));
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      din      = 16'sd1000;
      @(posedge clk); #1;
      chk("bp_hold_valid", int'(valid2 & valid0), 1);
      chk("bp_hold_out2", int'(out2), int'(v.e2));
      chk("bp_hold_out0", int'(out0), int'(v.e0));
      chk("bp_hold_ready", int'(in_ready2 | in_ready0), 0);
    end
    // Flush with a simultaneous accept: flush wins, sample dropped.
    flush     = 1'b1;
    din       = 16'sd500;
    frame_len = 7'd1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", int'(valid2 | valid0), 0);
    chk("flush_ready", int'(in_ready2 & in_ready0), 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_no_result", int'(valid2 | valid0), 0);
    v = mk(2, 2, 3, 4, 0, 0, 0, 0, 0, 0, Rnd ? 2 : 1, 7);
    feed(v);
    check_done("post_flush", int'(v.e2), int'(v.e0));
    check_release("post_flush");

    // Reset mid-frame: partial sum is lost, outputs clear at once.
    v = mk(4, 3, 100, 100, 100, 0, 0, 0, 0, 0, 0, 0);
    feed(v);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out2", int'(out2), 0);
    chk("mid_rst_out0", int'(out0), 0);
    chk("mid_rst_valid", int'(valid2 | valid0), 0);
    chk("mid_rst_ready", int'(in_ready2 | in_ready0), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_up", int'(in_ready2), 1);
    v = mk(4, 4, 1, 2, 3, 4, 0, 0, 0, 0, Rnd ? 3 : 2, 10);
    feed(v);
    check_done("after_rst", int'(v.e2), int'(v.e0));
    check_release("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
